adexp_bias_ctrl: RTL and testbench

- Digital controller beside the DPI AdExp analog neuron in the tile.
- Loads the neuron's bias DAC codes through a byte-wide, two-phase strobe protocol on the dedicated inputs, and drives the enable bits.
- Counts neuron spike events over a fixed window and publishes the firing-rate count on the outputs.
- All logic runs on the tile clock; the asynchronous pin inputs (strobe, spike) are synchronised internally.

---
 rtl/adexp_bias_ctrl.sv | 156 +++++++++++++++
 tb/tb_adexp_bias_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adexp_bias_ctrl.sv
// Bias/enable register loader and spike-rate counter for the DPI AdExp neuron.
// Byte-wide two-phase strobe writes/reads, windowed saturating spike count.
module adexp_bias_ctrl #(
  parameter int         NREG       = 8,
  parameter logic [7:0] RESET_BIAS = 8'h80,
  parameter int         WIN_LOG2   = 10,
  parameter int         TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              wr_data,
  input  logic                    wr_strobe,
  input  logic                    spike_in,
  output logic [8*(NREG-1)-1:0]   bias_bus,
  output logic                    neuron_en,
  output logic                    cnt_en,
  output logic [7:0]              rd_data,
  output logic                    rd_valid,
  output logic                    wr_ack,
  output logic                    err,
  output logic [7:0]              spike_count,
  output logic                    count_valid
);

  // state | meaning
  // IDLE  | waiting for a command byte (read or write-address)
  // ADDR  | write address latched, waiting for the data byte or timeout
  typedef enum logic {IDLE, ADDR} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]       TMR_LOAD = TW'(TIMEOUT);
  localparam logic [TW-1:0]       TMR_ONE  = TW'(1);
  localparam logic [WIN_LOG2-1:0] WIN_ONE  = WIN_LOG2'(1);

  state_t              state, state_nxt;
  logic                stb_s1, stb_s2, stb_d, stb;
  logic                spk_s1, spk_s2, spk_d, spk_edge;
  logic [7:0]          regs [NREG];
  logic [2:0]          addr;
  logic [TW-1:0]       tmr;
  logic [WIN_LOG2-1:0] win;
  logic [7:0]          acc;
  logic                do_wr, do_rd, go_addr, timeout;

  assign spk_edge  = spk_s2 & ~spk_d;
  assign neuron_en = regs[NREG-1][0];
  assign cnt_en    = regs[NREG-1][1];

  for (genvar g = 0; g < NREG - 1; g++) begin : g_bias
    assign bias_bus[8*g +: 8] = regs[g];
  end

  // Strobe pulse is registered once more so wr_data is sampled a full cycle after edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_s1 <= 1'b0;
      stb_s2 <= 1'b0;
      stb_d  <= 1'b0;
      stb    <= 1'b0;
      spk_s1 <= 1'b0;
      spk_s2 <= 1'b0;
      spk_d  <= 1'b0;
    end else begin
      stb_s1 <= wr_strobe;
      stb_s2 <= stb_s1;
      stb_d  <= stb_s2;
      stb    <= stb_s2 & ~stb_d;
      spk_s1 <= spike_in;
      spk_s2 <= spk_s1;
      spk_d  <= spk_s2;
    end
  end

  always_comb begin
    state_nxt = state;
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    go_addr   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (stb) begin
          if (wr_data[7]) begin
            go_addr   = 1'b1;
            state_nxt = ADDR;
          end else begin
            do_rd = 1'b1;
          end
        end
      end
      ADDR: begin
        if (stb) begin
          do_wr     = 1'b1;
          state_nxt = IDLE;
        end else if (tmr == '0) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      tmr      <= '0;
      err      <= 1'b0;
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      for (int i = 0; i < NREG - 1; i++) regs[i] <= RESET_BIAS;
      regs[NREG-1] <= '0;
    end else begin
      state    <= state_nxt;
      wr_ack   <= do_wr;
      rd_valid <= do_rd;
      if (go_addr) begin
        addr <= wr_data[2:0];
        tmr  <= TMR_LOAD;
        err  <= 1'b0;
      end else if (state == ADDR && tmr != '0) begin
        tmr <= tmr - TMR_ONE;
      end
      if (timeout) err <= 1'b1;
      if (do_wr) regs[addr] <= wr_data;
      if (do_rd) rd_data <= regs[wr_data[2:0]];
    end
  end

  // A spike edge on the wrap cycle seeds the next window rather than the one being published.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win         <= '0;
      acc         <= '0;
      spike_count <= '0;
      count_valid <= 1'b0;
    end else if (!cnt_en) begin
      win         <= '0;
      acc         <= '0;
      count_valid <= 1'b0;
    end else begin
      win <= win + WIN_ONE;
      if (&win) begin
        spike_count <= acc;
        count_valid <= 1'b1;
        acc         <= {7'b0, spk_edge};
      end else begin
        count_valid <= 1'b0;
        if (spk_edge && acc != 8'hFF) acc <= acc + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_adexp_bias_ctrl.sv
// Scoreboard bench for adexp_bias_ctrl: two instances (16- and 1024-cycle windows)
// share stimulus; a reference model predicts reads, acks, register state and window counts.
module tb_adexp_bias_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic wr_strobe = 1'b0;
  logic spike_in = 1'b0;

  logic [55:0] bias_a, bias_b;
  logic ne_a, ne_b, ce_a, ce_b, rdv_a, rdv_b, ack_a, ack_b, err_a, err_b, cv_a, cv_b;
  logic [7:0] rdd_a, rdd_b, sc_a, sc_b;

  adexp_bias_ctrl #(.WIN_LOG2(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_strobe(wr_strobe), .spike_in(spike_in),
    .bias_bus(bias_a), .neuron_en(ne_a), .cnt_en(ce_a), .rd_data(rdd_a), .rd_valid(rdv_a),
    .wr_ack(ack_a), .err(err_a), .spike_count(sc_a), .count_valid(cv_a));

  adexp_bias_ctrl dut_b (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_strobe(wr_strobe), .spike_in(spike_in),
    .bias_bus(bias_b), .neuron_en(ne_b), .cnt_en(ce_b), .rd_data(rdd_b), .rd_valid(rdv_b),
    .wr_ack(ack_b), .err(err_b), .spike_count(sc_b), .count_valid(cv_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct packed { int cyc; logic [7:0] d; } ev_t;
  typedef struct packed { int cyc; logic [2:0] a; logic [7:0] d; } wr_t;

  ev_t q_rd[$];
  ev_t q_ack[$];
  ev_t q_cnt0[$];
  ev_t q_cnt1[$];
  wr_t pend[$];

  logic [7:0] m_reg [8];
  logic m_err, m_on;
  int en_edge;
  int acc [2];
  logic h1, h2, h3;
  int spk_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [55:0] mbias();
    logic [55:0] b;
    for (int i = 0; i < 7; i++) b[i*8 +: 8] = m_reg[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 7; i++) m_reg[i] = 8'h80;
    m_reg[7] = 8'h00;
    m_err = 1'b0;
    m_on = 1'b0;
    en_edge = 0;
    acc[0] = 0;
    acc[1] = 0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    pend.delete();
  endtask

  // Edge k: a spike is counted two edges after its first high sample; windows are
  // 2^L edges long measured from the edge where the count enable took effect.
  task automatic model_step(input int k);
    logic ev;
    int n;
    wr_t w;
    ev = h2 & ~h3;
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? 16 : 1024;
      if (m_on) begin
        if (k != en_edge && ((k - en_edge) % n) == 0) begin
          if (d == 0) q_cnt0.push_back('{k, 8'(acc[d])});
          else        q_cnt1.push_back('{k, 8'(acc[d])});
          acc[d] = ev ? 1 : 0;
        end else begin
          acc[d] = acc[d] + (ev ? 1 : 0);
          if (acc[d] > 255) acc[d] = 255;
        end
      end else begin
        acc[d] = 0;
      end
    end
    h3 = h2; h2 = h1; h1 = spike_in;
    while (pend.size() > 0 && pend[0].cyc == k) begin
      w = pend.pop_front();
      m_reg[w.a] = w.d;
      if (w.a == 3'd7) begin
        if (w.d[1] && !m_on) en_edge = k;
        m_on = w.d[1];
      end
    end
  endtask

  initial begin : model
    forever begin
      @(posedge clk);
      if (rst_n) model_step(cyc + 1);
    end
  end

  initial begin : spikes
    forever begin
      case (spk_mode)
        1: begin
          repeat (5) begin
            spike_in = 1'b1; repeat (2) @(negedge clk);
            spike_in = 1'b0; @(negedge clk);
          end
          @(negedge clk);
        end
        2: begin
          spike_in = 1'b1; repeat (2) @(negedge clk);
          spike_in = 1'b0; @(negedge clk);
        end
        3: begin
          spike_in = 1'b1; repeat ($urandom_range(2, 4)) @(negedge clk);
          spike_in = 1'b0; repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        default: begin
          spike_in = 1'b0; @(negedge clk);
        end
      endcase
    end
  end

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rdv_a || rdv_b) begin
          if (q_rd.size() == 0) chk("rd_unexpected", 64'(1), 64'(0));
          else begin
            e = q_rd.pop_front();
            chk("rd_cycle", 64'(cyc), 64'(e.cyc));
            chk("rd_valid_pair", 64'({rdv_a, rdv_b}), 64'(2'b11));
            chk("rd_data_a", 64'(rdd_a), 64'(e.d));
            chk("rd_data_b", 64'(rdd_b), 64'(e.d));
          end
        end else if (q_rd.size() != 0 && q_rd[0].cyc < cyc) begin
          e = q_rd.pop_front();
          chk("rd_missing", 64'(0), 64'(1));
        end
        if (ack_a || ack_b) begin
          if (q_ack.size() == 0) chk("ack_unexpected", 64'(1), 64'(0));
          else begin
            e = q_ack.pop_front();
            chk("ack_cycle", 64'(cyc), 64'(e.cyc));
            chk("ack_pair", 64'({ack_a, ack_b}), 64'(2'b11));
          end
        end else if (q_ack.size() != 0 && q_ack[0].cyc < cyc) begin
          e = q_ack.pop_front();
          chk("ack_missing", 64'(0), 64'(1));
        end
        if (cv_a) begin
          if (q_cnt0.size() == 0) chk("cnt_a_unexpected", 64'(1), 64'(0));
          else begin
            e = q_cnt0.pop_front();
            chk("cnt_a_cycle", 64'(cyc), 64'(e.cyc));
            chk("cnt_a_value", 64'(sc_a), 64'(e.d));
          end
        end else if (q_cnt0.size() != 0 && q_cnt0[0].cyc < cyc) begin
          e = q_cnt0.pop_front();
          chk("cnt_a_missing", 64'(0), 64'(1));
        end
        if (cv_b) begin
          if (q_cnt1.size() == 0) chk("cnt_b_unexpected", 64'(1), 64'(0));
          else begin
            e = q_cnt1.pop_front();
            chk("cnt_b_cycle", 64'(cyc), 64'(e.cyc));
            chk("cnt_b_value", 64'(sc_b), 64'(e.d));
          end
        end else if (q_cnt1.size() != 0 && q_cnt1[0].cyc < cyc) begin
          e = q_cnt1.pop_front();
          chk("cnt_b_missing", 64'(0), 64'(1));
        end
      end
    end
  end

  // kind 0: write-address byte, 1: read command, 2: write data byte for address a
  task automatic send(input logic [7:0] d, input int kind, input logic [2:0] a);
    int e4;
    @(negedge clk);
    wr_data = d;
    wr_strobe = 1'b1;
    e4 = cyc + 4;
    if (kind == 1) q_rd.push_back('{e4, m_reg[a]});
    if (kind == 2) begin
      pend.push_back('{e4, a, d});
      q_ack.push_back('{e4, 8'h00});
    end
    repeat (4) @(negedge clk);
    wr_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs();
    chk("bias_a", 64'(bias_a), 64'(mbias()));
    chk("bias_b", 64'(bias_b), 64'(mbias()));
    chk("enables_a", 64'({ne_a, ce_a}), 64'({m_reg[7][0], m_reg[7][1]}));
    chk("enables_b", 64'({ne_b, ce_b}), 64'({m_reg[7][0], m_reg[7][1]}));
    chk("err_a", 64'(err_a), 64'(m_err));
    chk("err_b", 64'(err_b), 64'(m_err));
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] dat);
    send({1'b1, 4'($urandom), a}, 0, a);
    m_err = 1'b0;
    send(dat, 2, a);
    check_outputs();
  endtask

  task automatic rd(input logic [2:0] a);
    send({1'b0, 4'($urandom), a}, 1, a);
  endtask

  task automatic reset_checks();
    chk("rst_bias_a", 64'(bias_a), 64'(56'h80808080808080));
    chk("rst_bias_b", 64'(bias_b), 64'(56'h80808080808080));
    chk("rst_flags_a", 64'({ne_a, ce_a, err_a, rdv_a, ack_a, cv_a}), 64'(0));
    chk("rst_flags_b", 64'({ne_b, ce_b, err_b, rdv_b, ack_b, cv_b}), 64'(0));
    chk("rst_data_a", 64'({sc_a, rdd_a}), 64'(0));
    chk("rst_data_b", 64'({sc_b, rdd_b}), 64'(0));
  endtask

  task automatic do_reset();
    spk_mode = 0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_ops(input int n, input bit allow7);
    logic [2:0] a;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) rd(3'($urandom_range(0, 7)));
      else begin
        a = allow7 ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 6));
        wr(a, 8'($urandom));
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
  endtask

  initial begin : main
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    @(negedge clk);

    wr(3'd3, 8'h5A);
    chk("reg3_byte", 64'(bias_a[31:24]), 64'(8'h5A));
    rd(3'd3);
    rand_ops(12, 1'b0);

    spk_mode = 1;
    wr(3'd7, 8'h03);
    repeat (80) @(negedge clk);
    chk("rate_count5", 64'(sc_a), 64'(5));

    spk_mode = 2;
    repeat (1100) @(negedge clk);
    chk("sat_count255", 64'(sc_b), 64'(255));
    wr(3'd7, 8'h01);
    repeat (1500) @(negedge clk);
    chk("sat_hold255", 64'(sc_b), 64'(255));
    spk_mode = 0;

    send(8'h82, 0, 3'd2);
    m_err = 1'b0;
    repeat (300) @(negedge clk);
    m_err = 1'b1;
    check_outputs();
    chk("timeout_reg2", 64'(bias_a[23:16]), 64'(m_reg[2]));
    wr(3'd2, 8'h11);
    chk("reg2_after_to", 64'(bias_a[23:16]), 64'(8'h11));

    spk_mode = 3;
    wr(3'd7, 8'h03);
    repeat ($urandom_range(20, 200)) @(negedge clk);
    send(8'h85, 0, 3'd5);
    do_reset();
    send(8'h11, 1, 3'd1);
    check_outputs();

    spk_mode = 3;
    wr(3'd7, 8'h03);
    rand_ops(30, 1'b1);
    spk_mode = 0;
    repeat (40) @(negedge clk);
    chk("queues_drained",
        64'(q_rd.size() + q_ack.size() + q_cnt0.size() + q_cnt1.size() + pend.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
